harness_exit_monitor: RTL and testbench
=======================================

// Module: harness_exit_monitor
// PURPOSE
//  Synthesizable run controller for multi-hart RISC-V test benches and FPGA bring-up.
//  - Sequences DUT reset and counts run cycles.
//  - Watches each hart's tohost CSR and decides pass, fail or timeout.
//  - Counts memory read and write handshakes.
//  - Sits beside riscv_top and ExtMemModel; replaces behavioural exit and timeout checks.
// PARAMETERS
//  NUM_HARTS   1   number of monitored harts/CSR channels (1..16)
//  CSR_WIDTH   32  width of each tohost value
//  CYC_WIDTH   64  width of cycle counter and max_cycles
//  CNT_WIDTH   32  width of memory handshake counters
//  RESET_HOLD  10  cycles dut_reset stays high after monitor reset release (>=1)
//  MIN_CYCLES  2   csr>1 ignored while cycle_count < MIN_CYCLES
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    synchronous, active-low (0 = reset)
//  max_cycles     in   CYC_WIDTH            timeout limit; 0 disables timeout
//  csr            in   NUM_HARTS*CSR_WIDTH  tohost per hart; hart i at [i*CSR_WIDTH +: CSR_WIDTH]
//  mem_req_valid  in   1                    memory request valid
//  mem_req_ready  in   1                    memory request ready
//  mem_req_rw     in   1                    1 = write, 0 = read
//  dut_reset      out  1                    active-high reset to the DUT
//  running        out  1                    state == RUN
//  done           out  1                    run finished (sticky)
//  pass           out  1                    all harts reported tohost==1
//  timeout        out  1                    finished by timeout
//  fail_code      out  CSR_WIDTH            failing tohost value; 0 if pass or timeout
//  fail_hart      out  max(1,$clog2(NUM_HARTS))  lowest failing hart index
//  cycle_count    out  CYC_WIDTH            RUN cycles elapsed
//  mem_rd_count   out  CNT_WIDTH            accepted read requests
//  mem_wr_count   out  CNT_WIDTH            accepted write requests
// BEHAVIOUR
//  All outputs registered.
//  Reset (reset==0 at posedge):
//  - state=HOLD, dut_reset=1, hold counter=0.
//  - running/done/pass/timeout=0; fail_code/fail_hart/all counters=0; per-hart pass bits cleared.
//  - Reset mid-run aborts immediately to this state.
//  FSM HOLD -> RUN -> DONE.
//  HOLD:
//  - Hold counter increments each cycle.
//  - When it reaches RESET_HOLD-1: next state=RUN, dut_reset=0.
//  - dut_reset is therefore high for exactly RESET_HOLD cycles after reset release.
//  RUN:
//  - cycle_count += 1 per cycle; saturates at all-ones.
//  - valid&&ready with rw=0 -> mem_rd_count+1; with rw=1 -> mem_wr_count+1.
//  - Memory counters saturate. No counting outside RUN.
//  - Per hart each cycle: csr==1 sets that hart's sticky pass bit. Later csr values never clear it.
//  - Hart fails when csr>1 and cycle_count>=MIN_CYCLES. csr==0 means still running.
//  - Terminating events, same-cycle priority fail > timeout > pass:
//    - Fail: done=1, fail_code=csr of lowest failing hart, fail_hart=its index.
//    - Timeout: max_cycles!=0 && cycle_count>max_cycles -> done=1, timeout=1.
//    - Pass: all pass bits set, including bits set this cycle -> done=1, pass=1.
//  - Latency: status outputs are visible the cycle after the qualifying csr sample.
//  - The transition to DONE happens on the same edge.
//  DONE:
//  - Absorbing until reset. dut_reset reasserted to 1.
//  - All counters and status outputs frozen; inputs ignored.
//  Widths: comparisons are unsigned. csr is zero-extended as needed.
// TESTING
//  1 Reset release, RESET_HOLD=10 -> dut_reset high exactly 10 cycles; running=1 on cycle 11; cycle_count=1 the next cycle.
//  2 NUM_HARTS=2 staggered pass: hart0 csr=1 @cycle 20, hart1 csr=1 @cycle 50 -> done=pass=1 after cycle 50.
//    Check done stays 0 at cycle 49 and cycle_count freezes at 50.
//  3 Same-cycle conflict: hart0 csr=7, hart1 csr=1 while max_cycles=5 expires -> pass=0, timeout=0, fail_code=7, fail_hart=0.
//  4 Early garbage: csr=3 at cycle_count=1 with MIN_CYCLES=2 -> ignored; csr=1 later -> pass.
//  5 max_cycles=100, csr held 0 -> done=timeout=1, fail_code=0, cycle_count frozen at 101.
//    With max_cycles=0 there is no termination within 10k cycles.
//  6 Traffic: 3 reads, 2 writes, 4 valid-without-ready cycles -> rd=3, wr=2.
//    Drop reset mid-run -> all counters 0 and dut_reset=1 on the next cycle.

Source files
------------

// File: rtl/harness_exit_monitor_if.sv
// Memory request handshake observed by the exit monitor.
// The monitor only watches the bus, so its modport is input-only.
interface harness_exit_monitor_if;
  logic mem_req_valid;
  logic mem_req_ready;
  logic mem_req_rw;

  modport master (output mem_req_valid, output mem_req_ready, output mem_req_rw);
  modport slave  (input  mem_req_valid, input  mem_req_ready, input  mem_req_rw);
endinterface

// File: rtl/harness_exit_monitor.sv
// Run controller for multi-hart test benches: sequences DUT reset, counts run
// cycles and memory handshakes, and decides pass / fail / timeout from tohost.
module harness_exit_monitor #(
  parameter int unsigned NUM_HARTS  = 1,
  parameter int unsigned CSR_WIDTH  = 32,
  parameter int unsigned CYC_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned RESET_HOLD = 10,
  parameter int unsigned MIN_CYCLES = 2
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [CYC_WIDTH-1:0]                                max_cycles,
  input  logic [NUM_HARTS*CSR_WIDTH-1:0]                      csr,
  harness_exit_monitor_if.slave                               mem,
  output logic                                                dut_reset,
  output logic                                                running,
  output logic                                                done,
  output logic                                                pass,
  output logic                                                timeout,
  output logic [CSR_WIDTH-1:0]                                fail_code,
  output logic [((NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1)-1:0] fail_hart,
  output logic [CYC_WIDTH-1:0]                                cycle_count,
  output logic [CNT_WIDTH-1:0]                                mem_rd_count,
  output logic [CNT_WIDTH-1:0]                                mem_wr_count
);

  localparam int unsigned FH_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam int unsigned HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
  logic [NUM_HARTS-1:0]   r_pass_bits, w_pass_bits_nxt;

  logic                   w_dut_reset_nxt, w_running_nxt, w_done_nxt;
  logic                   w_pass_nxt, w_timeout_nxt;
  logic [CSR_WIDTH-1:0]   w_fail_code_nxt;
  logic [FH_W-1:0]        w_fail_hart_nxt;
  logic [CYC_WIDTH-1:0]   w_cycle_nxt;
  logic [CNT_WIDTH-1:0]   w_rd_nxt, w_wr_nxt;

  logic [NUM_HARTS-1:0]   w_csr_one;
  logic                   w_any_fail;
  logic [FH_W-1:0]        w_fail_idx;
  logic [CSR_WIDTH-1:0]   w_fail_val;
  logic                   w_min_ok;
  logic                   w_timeout_hit;
  logic                   w_all_pass;
  logic                   w_rd_hs, w_wr_hs;

  // Per-hart tohost decode; the lowest failing hart wins.
  always_comb begin
    w_csr_one  = '0;
    w_any_fail = 1'b0;
    w_fail_idx = '0;
    w_fail_val = '0;
    w_min_ok   = (cycle_count >= CYC_WIDTH'(MIN_CYCLES));
    for (int i = 0; i < int'(NUM_HARTS); i++) begin
      w_csr_one[i] = (csr[i*CSR_WIDTH +: CSR_WIDTH] == CSR_WIDTH'(1));
      if (!w_any_fail && w_min_ok && (csr[i*CSR_WIDTH +: CSR_WIDTH] > CSR_WIDTH'(1))) begin
        w_any_fail = 1'b1;
        w_fail_idx = FH_W'(i);
        w_fail_val = csr[i*CSR_WIDTH +: CSR_WIDTH];
      end
    end
    w_timeout_hit = (max_cycles != '0) && (cycle_count > max_cycles);
    w_all_pass    = &(r_pass_bits | w_csr_one);
    w_rd_hs       = mem.mem_req_valid && mem.mem_req_ready && !mem.mem_req_rw;
    w_wr_hs       = mem.mem_req_valid && mem.mem_req_ready &&  mem.mem_req_rw;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_pass_bits_nxt = r_pass_bits;
    w_dut_reset_nxt = dut_reset;
    w_running_nxt   = running;
    w_done_nxt      = done;
    w_pass_nxt      = pass;
    w_timeout_nxt   = timeout;
    w_fail_code_nxt = fail_code;
    w_fail_hart_nxt = fail_hart;
    w_cycle_nxt     = cycle_count;
    w_rd_nxt        = mem_rd_count;
    w_wr_nxt        = mem_wr_count;

    case (r_state)
      S_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt     = S_RUN;
          w_dut_reset_nxt = 1'b0;
          w_running_nxt   = 1'b1;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end

      S_RUN: begin
        w_pass_bits_nxt = r_pass_bits | w_csr_one;
        if (w_rd_hs && (mem_rd_count != '1)) w_rd_nxt = mem_rd_count + CNT_WIDTH'(1);
        if (w_wr_hs && (mem_wr_count != '1)) w_wr_nxt = mem_wr_count + CNT_WIDTH'(1);
        if (w_any_fail || w_timeout_hit || w_all_pass) begin
          // Terminating edge: cycle_count stays at the value that qualified.
          w_state_nxt     = S_DONE;
          w_dut_reset_nxt = 1'b1;
          w_running_nxt   = 1'b0;
          w_done_nxt      = 1'b1;
          if (w_any_fail) begin
            w_fail_code_nxt = w_fail_val;
            w_fail_hart_nxt = w_fail_idx;
          end else if (w_timeout_hit) begin
            w_timeout_nxt = 1'b1;
          end else begin
            w_pass_nxt = 1'b1;
          end
        end else if (cycle_count != '1) begin
          w_cycle_nxt = cycle_count + CYC_WIDTH'(1);
        end
      end

      S_DONE: begin
      end

      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_HOLD;
      r_hold       <= '0;
      r_pass_bits  <= '0;
      dut_reset    <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      fail_code    <= '0;
      fail_hart    <= '0;
      cycle_count  <= '0;
      mem_rd_count <= '0;
      mem_wr_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_pass_bits  <= w_pass_bits_nxt;
      dut_reset    <= w_dut_reset_nxt;
      running      <= w_running_nxt;
      done         <= w_done_nxt;
      pass         <= w_pass_nxt;
      timeout      <= w_timeout_nxt;
      fail_code    <= w_fail_code_nxt;
      fail_hart    <= w_fail_hart_nxt;
      cycle_count  <= w_cycle_nxt;
      mem_rd_count <= w_rd_nxt;
      mem_wr_count <= w_wr_nxt;
    end
  end

endmodule

// File: tb/tb_harness_exit_monitor.sv
// Randomized and directed bench for harness_exit_monitor with two harts; expected
// results come from scanning a whole stimulus trace for its first terminating event.
module tb_harness_exit_monitor;

  localparam int unsigned NH   = 2;
  localparam int unsigned CW   = 32;
  localparam int unsigned YW   = 64;
  localparam int unsigned NW   = 32;
  localparam int unsigned HOLD = 10;
  localparam int unsigned MINC = 2;
  localparam int          MAXL = 300;

  logic              clk = 1'b0;
  logic              reset;
  logic [YW-1:0]     max_cycles;
  logic [NH*CW-1:0]  csr;
  logic              dut_reset, running, done, pass, timeout;
  logic [CW-1:0]     fail_code;
  logic [0:0]        fail_hart;
  logic [YW-1:0]     cycle_count;
  logic [NW-1:0]     mem_rd_count, mem_wr_count;

  harness_exit_monitor_if mem_if ();

  harness_exit_monitor #(
    .NUM_HARTS(NH), .CSR_WIDTH(CW), .CYC_WIDTH(YW), .CNT_WIDTH(NW),
    .RESET_HOLD(HOLD), .MIN_CYCLES(MINC)
  ) u_dut (
    .clk(clk), .reset(reset), .max_cycles(max_cycles), .csr(csr), .mem(mem_if.slave),
    .dut_reset(dut_reset), .running(running), .done(done), .pass(pass),
    .timeout(timeout), .fail_code(fail_code), .fail_hart(fail_hart),
    .cycle_count(cycle_count), .mem_rd_count(mem_rd_count), .mem_wr_count(mem_wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus trace: index k is the cycle_count value when the sample is taken.
  logic [CW-1:0] t_csr0 [MAXL];
  logic [CW-1:0] t_csr1 [MAXL];
  logic          t_v [MAXL];
  logic          t_r [MAXL];
  logic          t_w [MAXL];

  // Expected outcome of a trace.
  int            e_k;
  logic          e_pass, e_to;
  logic [CW-1:0] e_fcode;
  int            e_fhart;
  int            e_rd, e_wr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_trace();
    for (int k = 0; k < MAXL; k++) begin
      t_csr0[k] = '0; t_csr1[k] = '0;
      t_v[k] = 1'b0; t_r[k] = 1'b0; t_w[k] = 1'b0;
    end
  endtask

  // First cycle where any hart fails, the limit is exceeded, or every hart has seen tohost==1.
  task automatic model(input int len, input longint unsigned maxc);
    bit seen0, seen1, f0, f1;
    seen0 = 0; seen1 = 0;
    e_k = len; e_pass = 0; e_to = 0; e_fcode = '0; e_fhart = 0; e_rd = 0; e_wr = 0;
    for (int k = 0; k < len; k++) begin
      if (t_v[k] && t_r[k]) begin
        if (t_w[k]) e_wr++; else e_rd++;
      end
      if (t_csr0[k] == 1) seen0 = 1;
      if (t_csr1[k] == 1) seen1 = 1;
      f0 = (t_csr0[k] > 1) && (k >= int'(MINC));
      f1 = (t_csr1[k] > 1) && (k >= int'(MINC));
      if (f0 || f1) begin
        e_k = k; e_fcode = f0 ? t_csr0[k] : t_csr1[k]; e_fhart = f0 ? 0 : 1;
        break;
      end else if (maxc != 0 && longint'(k) > longint'(maxc)) begin
        e_k = k; e_to = 1;
        break;
      end else if (seen0 && seen1) begin
        e_k = k; e_pass = 1;
        break;
      end
    end
  endtask

  task automatic drive_idle();
    csr = '0;
    mem_if.mem_req_valid = 1'b0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_req_rw    = 1'b0;
  endtask

  // Reset, release, and measure how long dut_reset stays high.
  task automatic reset_release(input string nm);
    int n;
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq({nm, ".rst_dut_reset"}, dut_reset, 1);
    check_eq({nm, ".rst_done"}, done, 0);
    check_eq({nm, ".rst_cycles"}, cycle_count, 0);
    reset = 1'b1;
    n = 0;
    while (dut_reset && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({nm, ".hold_len"}, 64'(n), 64'(HOLD));
    check_eq({nm, ".running"}, running, 1);
    check_eq({nm, ".cycles_at_run"}, cycle_count, 0);
  endtask

  task automatic run_trace(input string nm, input int len, input longint unsigned maxc);
    int exp_cc;
    model(len, maxc);
    max_cycles = 64'(maxc);
    reset_release(nm);
    for (int k = 0; k < len; k++) begin
      csr = {t_csr1[k], t_csr0[k]};
      mem_if.mem_req_valid = t_v[k];
      mem_if.mem_req_ready = t_r[k];
      mem_if.mem_req_rw    = t_w[k];
      @(posedge clk);
      #1;
      if (k == 0) check_eq({nm, ".first_count"}, cycle_count, (e_k == 0) ? 0 : 1);
      check_eq($sformatf("%s.done@%0d", nm, k), done, (k >= e_k) ? 1 : 0);
    end
    exp_cc = (e_k < len) ? e_k : len;
    check_eq({nm, ".done"}, done, (e_k < len) ? 1 : 0);
    check_eq({nm, ".pass"}, pass, e_pass);
    check_eq({nm, ".timeout"}, timeout, e_to);
    check_eq({nm, ".fail_code"}, fail_code, e_fcode);
    check_eq({nm, ".fail_hart"}, fail_hart, 64'(e_fhart));
    check_eq({nm, ".cycle_count"}, cycle_count, 64'(exp_cc));
    check_eq({nm, ".rd"}, mem_rd_count, 64'(e_rd));
    check_eq({nm, ".wr"}, mem_wr_count, 64'(e_wr));
    check_eq({nm, ".dut_reset"}, dut_reset, (e_k < len) ? 1 : 0);
    check_eq({nm, ".running"}, running, (e_k < len) ? 0 : 1);
  endtask

  task automatic random_trace();
    int p, f;
    logic [CW-1:0] fv, v;
    clear_trace();
    for (int h = 0; h < int'(NH); h++) begin
      p  = int'($urandom_range(5, 250));
      f  = ($urandom % 4 == 0) ? int'($urandom_range(0, 280)) : -1;
      fv = ($urandom % 2 == 0) ? CW'($urandom_range(2, 1000)) : ($urandom | CW'(2));
      for (int k = 0; k < MAXL; k++) begin
        v = '0;
        if (k < int'(MINC) && $urandom % 3 == 0) v = CW'($urandom_range(2, 9));
        if (k == p) v = 1;
        else if (k > p && $urandom % 2 == 0) v = 1;
        if (k == f) v = fv;
        if (h == 0) t_csr0[k] = v; else t_csr1[k] = v;
      end
    end
    for (int k = 0; k < MAXL; k++) begin
      t_v[k] = 1'($urandom); t_r[k] = 1'($urandom); t_w[k] = 1'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    max_cycles = '0;
    drive_idle();

    // Staggered pass across two harts.
    clear_trace();
    t_csr0[20] = 1;
    t_csr1[50] = 1;
    run_trace("stagger", 80, 0);
    check_eq("stagger.cc50", cycle_count, 50);
    check_eq("stagger.pass1", pass, 1);

    // Fail beats timeout and pass in the same cycle.
    clear_trace();
    t_csr0[6] = 7;
    t_csr1[6] = 1;
    run_trace("conflict", 20, 5);
    check_eq("conflict.code7", fail_code, 7);
    check_eq("conflict.hart0", fail_hart, 0);
    check_eq("conflict.no_to", timeout, 0);
    check_eq("conflict.no_pass", pass, 0);

    // Garbage before MIN_CYCLES is ignored.
    clear_trace();
    t_csr0[1]  = 3;
    t_csr0[10] = 1;
    t_csr1[10] = 1;
    run_trace("early", 30, 0);
    check_eq("early.pass1", pass, 1);
    check_eq("early.cc10", cycle_count, 10);

    // Timeout with tohost held at zero.
    clear_trace();
    run_trace("timeout", 150, 100);
    check_eq("timeout.flag", timeout, 1);
    check_eq("timeout.cc101", cycle_count, 101);

    // Memory traffic, then a mid-run reset.
    clear_trace();
    t_v[0] = 1; t_r[0] = 1; t_w[0] = 0;
    t_v[1] = 1;
    t_v[2] = 1; t_r[2] = 1; t_w[2] = 1;
    t_v[3] = 1;
    t_v[4] = 1; t_r[4] = 1;
    t_v[5] = 1; t_w[5] = 1;
    t_v[6] = 1; t_r[6] = 1; t_w[6] = 1;
    t_v[7] = 1; t_w[7] = 1;
    t_v[8] = 1; t_r[8] = 1;
    run_trace("traffic", 12, 0);
    check_eq("traffic.rd3", mem_rd_count, 3);
    check_eq("traffic.wr2", mem_wr_count, 2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midreset.dut_reset", dut_reset, 1);
    check_eq("midreset.running", running, 0);
    check_eq("midreset.cc", cycle_count, 0);
    check_eq("midreset.rd", mem_rd_count, 0);
    check_eq("midreset.wr", mem_wr_count, 0);

    // No limit: runs indefinitely while tohost stays zero.
    max_cycles = '0;
    reset_release("nolimit");
    for (int k = 0; k < 10000; k++) @(posedge clk);
    #1;
    check_eq("nolimit.done", done, 0);
    check_eq("nolimit.cc", cycle_count, 10000);

    // Randomized traces.
    for (int t = 0; t < 15; t++) begin
      longint unsigned mc;
      random_trace();
      mc = ($urandom % 3 == 0) ? 0 : longint'($urandom_range(20, 220));
      run_trace($sformatf("rand%0d", t), MAXL, mc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
